// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer with
// memory wait timeout, sticky timeout flag and retired-instruction counter.
module uc_multiciclo #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] instrucao,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                irWrite,
  output logic                iorD,
  output logic                regDst,
  output logic                aluSrcA,
  output logic                memtoReg,
  output logic                regWrite,
  output logic                memRead,
  output logic                memWrite,
  output logic                branch,
  output logic                branchNe,
  output logic                jump,
  output logic [1:0]          aluSrcB,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                trap,
  output logic                timeout,
  output logic [CNT_W-1:0]    retired,
  output logic [2:0]          estado
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_I   = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'b100010);
  localparam logic [OPCODE_W-1:0] OP_LWI = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'b101010);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6'b010000);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_retired;
  logic                w_legal;
  logic                w_wait_state;
  logic                w_timeout_hit;
  logic                w_retire;
  logic [1:0]          w_aluop;

  // Full-width compare, so any set bit above bit 5 makes the opcode illegal.
  always_comb begin
    w_legal = 1'b0;
    case (instrucao)
      OP_R, OP_I, OP_LW, OP_LWI, OP_SW, OP_BEQ, OP_BNE, OP_J: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_wait_state  = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout_hit = w_wait_state && !memReady &&
                         (r_wait == WAIT_W'(WAIT_MAX - 1));

  assign w_retire = (r_state == S_WB) ||
                    ((r_state == S_MEM) && memReady && (r_opcode == OP_SW)) ||
                    ((r_state == S_EXEC) &&
                     ((r_opcode == OP_BEQ) || (r_opcode == OP_BNE) || (r_opcode == OP_J)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (memReady)           w_state_next = S_DECODE;
        else if (w_timeout_hit) w_state_next = S_TRAP;
      end
      S_DECODE: w_state_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (r_opcode)
          OP_R, OP_I, OP_LWI: w_state_next = S_WB;
          OP_LW, OP_SW:       w_state_next = S_MEM;
          default:            w_state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (memReady)           w_state_next = (r_opcode == OP_LW) ? S_WB : S_FETCH;
        else if (w_timeout_hit) w_state_next = S_TRAP;
      end
      S_WB:    w_state_next = S_FETCH;
      S_TRAP:  w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  // Wait counter restarts on any state change, so entering FETCH/MEM sees 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode  <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
      r_retired <= '0;
    end else begin
      if (r_state == S_DECODE) r_opcode <= instrucao;
      if (w_state_next != r_state)            r_wait <= '0;
      else if (w_wait_state && !memReady)     r_wait <= r_wait + 1'b1;
      if (w_timeout_hit)                      r_timeout <= 1'b1;
      if (w_retire)                           r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    pcWrite  = 1'b0;
    irWrite  = 1'b0;
    iorD     = 1'b0;
    regDst   = 1'b0;
    aluSrcA  = 1'b0;
    memtoReg = 1'b0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    branch   = 1'b0;
    branchNe = 1'b0;
    jump     = 1'b0;
    aluSrcB  = 2'b00;
    w_aluop  = 2'b00;
    trap     = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        // Fetch strobes are held off while reset is asserted.
        irWrite = memReady & rst_n;
        pcWrite = memReady & rst_n;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        w_aluop = 2'b00;
      end
      S_EXEC: begin
        case (r_opcode)
          OP_R:         begin aluSrcA = 1'b1; aluSrcB = 2'b00; w_aluop = 2'b10; end
          OP_I:         begin aluSrcA = 1'b1; aluSrcB = 2'b10; w_aluop = 2'b10; end
          OP_LWI:       begin aluSrcA = 1'b1; aluSrcB = 2'b10; w_aluop = 2'b01; end
          OP_LW, OP_SW: begin aluSrcA = 1'b1; aluSrcB = 2'b10; w_aluop = 2'b00; end
          OP_BEQ:       begin aluSrcA = 1'b1; aluSrcB = 2'b00; w_aluop = 2'b01; branch = 1'b1; end
          OP_BNE:       begin aluSrcA = 1'b1; aluSrcB = 2'b00; w_aluop = 2'b01; branchNe = 1'b1; end
          OP_J:         begin jump = 1'b1; pcWrite = 1'b1; end
          default:      ;
        endcase
      end
      S_MEM: begin
        iorD     = 1'b1;
        memRead  = (r_opcode == OP_LW);
        memWrite = (r_opcode == OP_SW);
      end
      S_WB: begin
        regWrite = 1'b1;
        regDst   = (r_opcode == OP_R) || (r_opcode == OP_I);
        memtoReg = (r_opcode == OP_LW);
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign aluOp   = ALUOP_W'(w_aluop);
  assign timeout = r_timeout;
  assign retired = r_retired;
  assign estado  = r_state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Randomized instruction-level bench: each instruction is expanded into the
// expected per-cycle state/strobe trace and checked against the control unit.
module tb_uc_multiciclo;

  localparam int OPW   = 8;
  localparam int AOW   = 3;
  localparam int WMAX  = 15;
  localparam int CW    = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [OPW-1:0]  instrucao = '0;
  logic            memReady = 1'b0;
  logic            pcWrite, irWrite, iorD, regDst, aluSrcA, memtoReg, regWrite;
  logic            memRead, memWrite, branch, branchNe, jump, trap, timeout;
  logic [1:0]      aluSrcB;
  logic [AOW-1:0]  aluOp;
  logic [CW-1:0]   retired;
  logic [2:0]      estado;

  uc_multiciclo #(.OPCODE_W(OPW), .ALUOP_W(AOW), .WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite), .iorD(iorD), .regDst(regDst),
    .aluSrcA(aluSrcA), .memtoReg(memtoReg), .regWrite(regWrite),
    .memRead(memRead), .memWrite(memWrite), .branch(branch),
    .branchNe(branchNe), .jump(jump), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .trap(trap), .timeout(timeout), .retired(retired), .estado(estado)
  );

  always #5 clk = ~clk;

  // Packed view of every strobe/select, bit 0 = trap.
  localparam logic [17:0] PCW = 18'h1 << 17, IRW = 18'h1 << 16, IORD = 18'h1 << 15,
                          RDST = 18'h1 << 14, SRCA = 18'h1 << 13, M2R = 18'h1 << 12,
                          RW = 18'h1 << 11, MR = 18'h1 << 10, MW = 18'h1 << 9,
                          BR = 18'h1 << 8, BNE = 18'h1 << 7, JMP = 18'h1 << 6,
                          TRP = 18'h1;
  function automatic logic [17:0] sb(input int v); return 18'(v) << 4; endfunction
  function automatic logic [17:0] ao(input int v); return 18'(v) << 1; endfunction

  wire [17:0] w_word = {pcWrite, irWrite, iorD, regDst, aluSrcA, memtoReg, regWrite,
                        memRead, memWrite, branch, branchNe, jump, aluSrcB, aluOp, trap};

  localparam logic [7:0] C_R = 8'h00, C_I = 8'h01, C_LW = 8'h22, C_LWI = 8'h23,
                         C_SW = 8'h2A, C_BEQ = 8'h04, C_BNE = 8'h06, C_J = 8'h10;
  logic [7:0] legal_ops [8] = '{C_R, C_I, C_LW, C_LWI, C_SW, C_BEQ, C_BNE, C_J};

  int n_cmp = 0;
  int n_bad = 0;
  int m_retired = 0;
  int m_timeout = 0;
  int n_instr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive memReady, check outputs at negedge, advance past posedge.
  task automatic do_cycle(input logic rdy, input int exp_st, input logic [17:0] exp_w,
                          input string tag);
    memReady = rdy;
    @(negedge clk);
    check({tag, ".estado"}, 32'(estado), 32'(exp_st));
    check({tag, ".ctrl"}, 32'(w_word), 32'(exp_w));
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input logic [7:0] op);
    foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Memory phase: wn cycles not ready then one ready cycle; wn >= WMAX times out.
  task automatic mem_phase(input int wn, input int st, input logic [17:0] w_wait,
                           input logic [17:0] w_done, input string tag, output bit timed_out);
    timed_out = 1'b0;
    if (wn >= WMAX) begin
      for (int c = 0; c < WMAX; c++) do_cycle(1'b0, st, w_wait, tag);
      do_cycle(1'($urandom), 5, TRP, {tag, ".trap"});
      m_timeout = 1;
      timed_out = 1'b1;
    end else begin
      for (int c = 0; c < wn; c++) do_cycle(1'b0, st, w_wait, tag);
      do_cycle(1'b1, st, w_done, tag);
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input int wf, input int wm);
    bit to;
    bit done;
    logic [17:0] ex_w;
    int next_st;
    done = 1'b0;
    instrucao = op;
    mem_phase(wf, 0, MR | sb(1), MR | sb(1) | IRW | PCW, "fetch", to);
    if (to) done = 1'b1;
    if (!done) begin
      do_cycle(1'($urandom), 1, sb(3) | ao(0), "decode");
      if (!is_legal(op)) begin
        do_cycle(1'($urandom), 5, TRP, "illegal");
        done = 1'b1;
      end
    end
    if (!done) begin
      next_st = 4;
      case (op)
        C_R:    ex_w = SRCA | sb(0) | ao(2);
        C_I:    ex_w = SRCA | sb(2) | ao(2);
        C_LWI:  ex_w = SRCA | sb(2) | ao(1);
        C_BEQ:  begin ex_w = SRCA | sb(0) | ao(1) | BR;  next_st = 0; end
        C_BNE:  begin ex_w = SRCA | sb(0) | ao(1) | BNE; next_st = 0; end
        C_J:    begin ex_w = JMP | PCW;                  next_st = 0; end
        default: begin ex_w = SRCA | sb(2) | ao(0);      next_st = 3; end
      endcase
      do_cycle(1'($urandom), 2, ex_w, "exec");
      if (next_st == 0) begin
        m_retired++;
        done = 1'b1;
      end else if (next_st == 3) begin
        ex_w = (op == C_LW) ? (IORD | MR) : (IORD | MW);
        mem_phase(wm, 3, ex_w, ex_w, "mem", to);
        if (to) done = 1'b1;
        else if (op == C_SW) begin
          m_retired++;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      ex_w = RW;
      if (op == C_R || op == C_I) ex_w |= RDST;
      if (op == C_LW) ex_w |= M2R;
      do_cycle(1'($urandom), 4, ex_w, "wb");
      m_retired++;
    end
    m_retired &= (1 << CW) - 1;
    check("retired", 32'(retired), 32'(m_retired));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("back_in_fetch", 32'(estado), 32'd0);
    n_instr++;
    $display("instr %0d: op=%02h wf=%0d wm=%0d retired=%0d timeout=%0d",
             n_instr, op, wf, wm, retired, timeout);
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 0;
    if (r < 8) return $urandom_range(1, 4);
    if (r == 8) return WMAX - 1;
    return WMAX;
  endfunction

  initial begin
    logic [7:0] op;
    // Reset state, with memReady high to show fetch strobes stay off.
    memReady = 1'b1;
    #12;
    check("rst.estado", 32'(estado), 32'd0);
    check("rst.ctrl", 32'(w_word), 32'(MR | sb(1)));
    check("rst.retired", 32'(retired), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases.
    run_instr(C_R, 0, 0);
    run_instr(C_LW, 0, 3);
    run_instr(8'h3F, 0, 0);
    run_instr(C_R | 8'h40, 0, 0);
    run_instr(C_I, WMAX - 1, 0);
    run_instr(C_SW, 0, WMAX - 1);
    run_instr(C_J, WMAX, 0);
    run_instr(C_BEQ, 0, 0);
    run_instr(C_LW, 0, WMAX);

    // Randomized stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 7)];
      else if ($urandom_range(0, 1) == 1) op = legal_ops[$urandom_range(0, 7)] | 8'h80;
      else op = 8'($urandom);
      run_instr(op, rand_wait(), rand_wait());
    end

    // Counter wrap via J instructions.
    while (m_retired != (1 << CW) - 1) run_instr(C_J, 0, 0);
    check("wrap.allones", 32'(retired), 32'((1 << CW) - 1));
    run_instr(C_J, 0, 0);
    check("wrap.zero", 32'(retired), 32'd0);

    // Reset asserted during SW memory phase.
    instrucao = C_SW;
    do_cycle(1'b1, 0, MR | sb(1) | IRW | PCW, "rsw.fetch");
    do_cycle(1'b0, 1, sb(3), "rsw.decode");
    do_cycle(1'b0, 2, SRCA | sb(2), "rsw.exec");
    memReady = 1'b0;
    @(negedge clk);
    check("rsw.memwrite_before", 32'(memWrite), 32'd1);
    #2;
    memReady = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rsw.memwrite_after", 32'(memWrite), 32'd0);
    check("rsw.estado", 32'(estado), 32'd0);
    check("rsw.timeout", 32'(timeout), 32'd0);
    check("rsw.ctrl", 32'(w_word), 32'(MR | sb(1)));
    @(posedge clk); #1;
    check("rsw.retired", 32'(retired), 32'd0);
    rst_n = 1'b1;
    m_retired = 0;
    m_timeout = 0;
    run_instr(C_LWI, 0, 0);
    run_instr(C_BNE, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
